bcd_converter: RTL and testbench
================================

# bcd_converter

Sequential binary-to-BCD converter sitting between the CPU's display register output (32-bit) and the eight seven-segment digit decoders on the DE2 board. It converts a latched binary word to packed decimal digits using the shift-and-add-3 (double dabble) algorithm, one bit per clock. It presents the low eight decimal digits plus an overflow flag, so the HEX displays can show values in decimal instead of hex.

## Interface
- `WIDTH`, 32: binary input width.
- `DIGITS`, 8: number of BCD digits presented on `bcd`.
- `clk` in 1: system clock (CLOCK_50 domain); all logic on rising edge.
- `rst` in 1: reset; synchronous and active-high.
- `start` in 1: request conversion of `bin`; sampled every cycle.
- `bin` in WIDTH: binary value, sampled only in the cycle `start` is accepted.
- `busy` out 1: high while a conversion is in progress (RUN state).
- `done` out 1: one-cycle pulse; `bcd`/`overflow` valid and newly updated in this cycle.
- `bcd` out 4*DIGITS: packed BCD, digit 0 (units) in bits [3:0]; value mod 10^DIGITS.
- `overflow` out 1: set when converted value ≥ 10^DIGITS.

## Operation
- Internal scratch: IDIG = ceil(WIDTH/3) BCD digits (11 for WIDTH=32) plus a WIDTH-bit shift register holding remaining binary bits; bit counter of clog2(WIDTH+1) bits.
- States: IDLE, RUN, DONE.
  - IDLE: `start`=1 → latch `bin` into shift register, clear scratch digits, clear counter, go RUN. Else stay.
  - RUN: each cycle, for every scratch digit ≥5 add 3 (all digits in parallel, 4-bit result), then shift {scratch, shiftreg} left one bit (binary MSB enters digit 0 LSB). Counter increments. After the WIDTH-th shift go DONE.
  - DONE: `done`=1. `start`=1 → accept new conversion exactly as in IDLE, go RUN; else go IDLE.
- On the transition RUN→DONE, register `bcd` ← low DIGITS scratch digits (post-final-shift), `overflow` ← OR of digits DIGITS..IDIG-1 nonzero.
- `bcd` and `overflow` hold their values until the next RUN→DONE transition; they do not change during a conversion.
- `start` while in RUN ignored; `bin` changes during RUN have no effect.
- Add-3 applies before the shift, never after the final shift.

## Timing
- Reset (sync, `rst`=1 at rising edge): state IDLE, `busy`=0, `done`=0, `bcd`=0, `overflow`=0, counter and scratch cleared. Reset mid-RUN aborts the conversion; no `done` issued; previous `bcd` is lost (zero).
- `start` accepted at edge T (state IDLE or DONE) → `busy`=1 cycles T+1..T+WIDTH → `done`=1 and new `bcd` in cycle T+WIDTH+1.
- Latency WIDTH+1 cycles (33 at default) from accepting edge to `done`.
- `start` held high: back-to-back conversions, `done` every WIDTH+1 cycles, `busy` low only during DONE cycles.
- `busy` and `done` never high simultaneously.
- `start` and `rst` together: reset wins.

## Structure
- Shared package `bcd_pkg`: state enum (IDLE/RUN/DONE), default WIDTH/DIGITS constants, IDIG derivation function (ceil(WIDTH/3)).
- One sub-module `bcd_digit_adj`: purely combinational 4-bit add-3-if-≥5; instantiated IDIG times via generate.
- Top-level integration: `bcd` nibbles drive the eight digit decoders; `start` tied high for continuous refresh.

## Test plan
- `bin`=0, single `start` pulse → `done` exactly 33 cycles later, `bcd`=0x00000000, `overflow`=0.
- `bin`=12345678 → `bcd`=0x12345678, `overflow`=0; `bin`=99999999 → `bcd`=0x99999999, `overflow`=0.
- `bin`=100000000 → `bcd`=0x00000000, `overflow`=1; `bin`=0xFFFFFFFF (4294967295) → `bcd`=0x94967295, `overflow`=1.
- `start` held high with `bin`=255 → `done` pulses every 33 cycles, `bcd`=0x00000255 each time; `busy` low only on `done` cycles.
- `start` re-pulsed with `bin`=7 during RUN of 42 → ignored, result 0x00000042; `bcd` unchanged mid-conversion.
- `rst` asserted 10 cycles into a conversion → next cycle `busy`=0, `bcd`=0, no `done`; fresh `start` then converts normally.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM states, default
// widths and the scratch-digit count derivation.
package bcd_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_DIGITS = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Decimal digits needed to hold any WIDTH-bit value: ceil(width/3).
  function automatic int unsigned bcd_idig(input int unsigned width);
    return (width + 32'd2) / 32'd3;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more so
// the following left shift carries correctly into the next decimal digit.
// Ports:
//   din    - current scratch digit
//   dout_c - corrected digit (combinational, 4-bit wrap)
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout_c
);

  assign dout_c = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Ports:
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   start     - request conversion of bin (accepted in IDLE or DONE)
//   bin       - binary input, sampled only when start is accepted
//   busy      - conversion in progress
//   done      - one-cycle pulse, bcd/overflow freshly updated
//   bcd       - low DIGITS decimal digits, units in [3:0]
//   overflow  - converted value does not fit in DIGITS digits
module bcd_converter
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow
);

  localparam int unsigned IDIG = bcd_idig(WIDTH);
  localparam int unsigned SW   = 4 * IDIG;
  localparam int unsigned BW   = 4 * DIGITS;
  localparam int unsigned CW   = $clog2(WIDTH + 1);

  state_e          state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [SW-1:0]    scratch_q, scratch_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;

  logic [SW-1:0]          adj_c;
  logic [SW+WIDTH-1:0]    cat_c;
  logic                   high_nz_c;

  // Per-digit add-3 correction, all digits in parallel.
  for (genvar g = 0; g < IDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din    (scratch_q[4*g +: 4]),
      .dout_c (adj_c[4*g +: 4])
    );
  end

  // Corrected digits and remaining binary bits shifted left as one register;
  // the binary MSB enters the units digit LSB.
  assign cat_c = {adj_c, shreg_q} << 1;

  // Any nonzero digit above the presented ones after the shift means overflow.
  always_comb begin
    high_nz_c = 1'b0;
    for (int i = DIGITS; i < IDIG; i++) begin
      high_nz_c = high_nz_c | (|cat_c[WIDTH + 4*i +: 4]);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          shreg_d   = bin;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        scratch_d = cat_c[SW+WIDTH-1:WIDTH];
        shreg_d   = cat_c[WIDTH-1:0];
        cnt_d     = cnt_q + CW'(1);
        // This cycle performs the final shift: publish the result.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          bcd_d   = cat_c[WIDTH +: BW];
          ovf_d   = high_nz_c;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Directed bench for bcd_converter with hand-computed decimal results.
module tb_bcd_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] bin;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_converter dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One conversion from IDLE/DONE; optional re-pulse of start (bin=7) at cycle
  // repulse_at of the run, which must be ignored.
  task automatic convert(input string tag, input logic [31:0] value,
                         input logic [31:0] exp_bcd, input logic exp_ovf,
                         input int repulse_at);
    int          lat;
    bit          seen;
    bit          moved;
    bit          both;
    logic [31:0] prev_bcd;
    @(negedge clk);
    bin      = value;
    start    = 1'b1;
    prev_bcd = bcd;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 1;
    seen  = 1'b0;
    moved = 1'b0;
    both  = 1'b0;
    while (!seen && lat < 100) begin
      if (lat == repulse_at) begin
        start = 1'b1;
        bin   = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (busy && done) both = 1'b1;
      if (done) seen = 1'b1;
      else if (bcd !== prev_bcd) moved = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'd33);
    check({tag, "_bcd"}, 64'(bcd), 64'(exp_bcd));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_bcd_hold"}, 64'(moved), 64'd0);
    check({tag, "_busy_done_excl"}, 64'(both), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc, ndone, last, first_done;
    bit  spacing_ok, busy_ok, bcd_ok, any_done;

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bcd", 64'(bcd), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    convert("zero",  32'd0,          32'h0000_0000, 1'b0, -1);
    convert("c1234", 32'd12345678,   32'h1234_5678, 1'b0, -1);
    convert("c9999", 32'd99999999,   32'h9999_9999, 1'b0, -1);
    convert("c1e8",  32'd100000000,  32'h0000_0000, 1'b1, -1);
    convert("cmax",  32'hFFFF_FFFF,  32'h9496_7295, 1'b1, -1);

    // start held high: continuous refresh
    @(negedge clk);
    bin        = 32'd255;
    start      = 1'b1;
    cyc        = 0;
    ndone      = 0;
    last       = 0;
    first_done = 0;
    spacing_ok = 1'b1;
    busy_ok    = 1'b1;
    bcd_ok     = 1'b1;
    while (ndone < 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (busy == done) busy_ok = 1'b0;
      if (done) begin
        ndone++;
        if (ndone == 1) first_done = cyc;
        else if (cyc - last != 33) spacing_ok = 1'b0;
        last = cyc;
        if (bcd !== 32'h0000_0255 || overflow !== 1'b0) bcd_ok = 1'b0;
      end
    end
    start = 1'b0;
    check("held_ndone", 64'(ndone), 64'd3);
    check("held_first", 64'(first_done), 64'd33);
    check("held_spacing", 64'(spacing_ok), 64'd1);
    check("held_busy", 64'(busy_ok), 64'd1);
    check("held_bcd", 64'(bcd_ok), 64'd1);
    @(posedge clk); #1;
    check("held_idle_busy", 64'(busy), 64'd0);
    check("held_idle_done", 64'(done), 64'd0);

    convert("repulse", 32'd42, 32'h0000_0042, 1'b0, 5);

    // reset ten cycles into a conversion
    @(negedge clk);
    bin   = 32'd99;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_bcd", 64'(bcd), 64'd0);
    check("mid_rst_ovf", 64'(overflow), 64'd0);
    any_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) any_done = 1'b1;
    end
    check("mid_rst_quiet", 64'(any_done), 64'd0);

    convert("after_rst", 32'd2024, 32'h0000_2024, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
